capture_trigger: RTL and testbench

CAPTURE_TRIGGER -- requirements
Module: capture_trigger

---
 rtl/capture_trigger.sv | 148 ++++++++++++++
 tb/tb_capture_trigger.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/capture_trigger.sv
// Triggered oscilloscope capture: arms on run, fires on a level crossing (or timeout),
// fills a DEPTH-sample frame, and publishes it to data_display on the next vblnk rise.
module capture_trigger #(
    parameter int DATA_W       = 12,
    parameter int DEPTH        = 256,
    parameter int AUTO_TIMEOUT = 1_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] sample,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              trig_slope,
    input  logic              run,
    input  logic              vblnk,
    output logic [DATA_W-1:0] data_display [0:DEPTH-1],
    output logic              frame_ready,
    output logic              triggered,
    output logic              busy
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int TMO_W = (AUTO_TIMEOUT > 1) ? $clog2(AUTO_TIMEOUT) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(AUTO_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ARM, CAPTURE, WAIT_FRAME} state_t;

    state_t             state_reg;
    state_t             state_next;
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [TMO_W-1:0]   tmo_reg;
    logic [DATA_W-1:0]  prev_reg;
    logic               has_prev_reg;
    logic               auto_reg;
    logic               vblnk_d_reg;
    logic [DATA_W-1:0]  cap_buf [0:DEPTH-1];
    logic [DEPTH-1:0]   wr_en;

    logic rise_hit, fall_hit, real_hit, tmo_hit, vblnk_rise;
    logic arm_clear, trig_fire, cap_write, publish;

    assign rise_hit   = has_prev_reg && (prev_reg < trig_level) && (sample >= trig_level);
    assign fall_hit   = has_prev_reg && (prev_reg > trig_level) && (sample <= trig_level);
    assign real_hit   = trig_slope ? fall_hit : rise_hit;
    assign tmo_hit    = (tmo_reg == TMO_MAX);
    assign vblnk_rise = vblnk && !vblnk_d_reg;
    assign busy       = (state_reg != IDLE);

    always_comb begin
        state_next = state_reg;
        arm_clear  = 1'b0;
        trig_fire  = 1'b0;
        cap_write  = 1'b0;
        publish    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (run) begin
                    state_next = ARM;
                    arm_clear  = 1'b1;
                end
            end
            ARM: begin
                if (!run) begin
                    state_next = IDLE;
                end else if (sample_valid && (real_hit || tmo_hit)) begin
                    state_next = CAPTURE;
                    trig_fire  = 1'b1;
                end
            end
            CAPTURE: begin
                if (sample_valid) begin
                    cap_write = 1'b1;
                    if (wr_ptr_reg == LAST_PTR) state_next = WAIT_FRAME;
                end
            end
            WAIT_FRAME: begin
                // run only decides where we go after publishing; it never aborts a frame
                if (vblnk_rise) begin
                    publish = 1'b1;
                    if (run) begin
                        state_next = ARM;
                        arm_clear  = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg    <= IDLE;
            wr_ptr_reg   <= '0;
            tmo_reg      <= '0;
            prev_reg     <= '0;
            has_prev_reg <= 1'b0;
            auto_reg     <= 1'b0;
            vblnk_d_reg  <= 1'b0;
            frame_ready  <= 1'b0;
            triggered    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            vblnk_d_reg <= vblnk;
            frame_ready <= publish;
            if (arm_clear) begin
                tmo_reg      <= '0;
                prev_reg     <= '0;
                has_prev_reg <= 1'b0;
            end else if (state_reg == ARM) begin
                if (!tmo_hit) tmo_reg <= tmo_reg + 1'b1;
                if (sample_valid) begin
                    prev_reg     <= sample;
                    has_prev_reg <= 1'b1;
                end
            end
            if (trig_fire) begin
                wr_ptr_reg <= PTR_W'(1);
                auto_reg   <= !real_hit;
            end else if (cap_write) begin
                wr_ptr_reg <= (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + 1'b1;
            end
            if (publish) triggered <= !auto_reg;
        end
    end

    // The triggering sample always lands in entry 0; later samples follow the pointer.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
        assign wr_en[gi] = (trig_fire && (gi == 0)) ||
                           (cap_write && (wr_ptr_reg == PTR_W'(gi)));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                cap_buf[i]      <= '0;
                data_display[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_en[i]) cap_buf[i] <= sample;
                if (publish)  data_display[i] <= cap_buf[i];
            end
        end
    end

endmodule

// File: tb/tb_capture_trigger.sv
// Bench for capture_trigger: trigger-condition table, hand-built timing sequences,
// and randomized streams checked against an array-scanning frame predictor.
module tb_capture_trigger;
    localparam int DW    = 12;
    localparam int DEPTH = 256;
    localparam int AUTO  = 100;
    localparam int NR    = 1500;
    localparam int MAXF  = 8;

    typedef struct {
        logic [DW-1:0] level;
        logic          slope;
        logic [DW-1:0] prev;
        logic [DW-1:0] cur;
        logic          exp_trig;
    } tvec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] sample = '0;
    logic          sample_valid = 1'b0;
    logic [DW-1:0] trig_level = '0;
    logic          trig_slope = 1'b0;
    logic          run = 1'b0;
    logic          vblnk = 1'b0;
    logic [DW-1:0] data_display [0:DEPTH-1];
    logic          frame_ready;
    logic          triggered;
    logic          busy;

    always #5 clk = ~clk;

    capture_trigger #(.DATA_W(DW), .DEPTH(DEPTH), .AUTO_TIMEOUT(AUTO)) dut (
        .clk(clk), .rst(rst), .sample(sample), .sample_valid(sample_valid),
        .trig_level(trig_level), .trig_slope(trig_slope), .run(run), .vblnk(vblnk),
        .data_display(data_display), .frame_ready(frame_ready),
        .triggered(triggered), .busy(busy)
    );

    int            vectors = 0;
    int            miscompares = 0;
    logic [DW-1:0] exp_disp  [0:DEPTH-1];
    logic [DW-1:0] frame_mem [0:MAXF-1][0:DEPTH-1];
    int            pub_cyc   [0:MAXF-1];
    logic          pub_trig  [0:MAXF-1];
    int            nexp;
    logic [DW-1:0] smp [0:NR-1];
    logic          vld [0:NR-1];
    logic          vbl [0:NR-1];
    tvec_t         tbl [0:9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_disp(input string name);
        int bad;
        bad = -1;
        vectors++;
        for (int i = 0; i < DEPTH; i++)
            if (bad < 0 && data_display[i] !== exp_disp[i]) bad = i;
        if (bad >= 0) begin
            miscompares++;
            $display("FAIL %s: data_display[%0d] got %0d expected %0d",
                     name, bad, data_display[bad], exp_disp[bad]);
        end
    endtask

    task automatic fill_exp(input int base, input int step);
        for (int i = 0; i < DEPTH; i++) exp_disp[i] = DW'((base + i * step) % 4096);
    endtask

    task automatic do_reset();
        rst = 1'b0; run = 1'b0; sample_valid = 1'b0; vblnk = 1'b0; sample = '0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    // Scans the stimulus arrays frame by frame: find the trigger, collect DEPTH valid
    // samples, then find the first vblnk rise after the frame is complete.
    task automatic predict(input logic [DW-1:0] lvl, input logic slp);
        int a, n, c, k;
        logic [DW-1:0] prev;
        logic has_prev, real_hit, hit;
        nexp = 0;
        a = 1;
        while (nexp < MAXF) begin
            has_prev = 1'b0; prev = '0; hit = 1'b0; real_hit = 1'b0; n = a;
            while (n < NR && !hit) begin
                if (vld[n]) begin
                    if (slp) real_hit = has_prev && (prev > lvl) && (smp[n] <= lvl);
                    else     real_hit = has_prev && (prev < lvl) && (smp[n] >= lvl);
                    if (real_hit || (n - a) >= AUTO - 1) hit = 1'b1;
                    else begin
                        prev = smp[n];
                        has_prev = 1'b1;
                    end
                end
                if (!hit) n++;
            end
            if (!hit) break;
            frame_mem[nexp][0] = smp[n];
            k = 1;
            c = n;
            while (k < DEPTH && c < NR - 1) begin
                c++;
                if (vld[c]) begin
                    frame_mem[nexp][k] = smp[c];
                    k++;
                end
            end
            if (k < DEPTH) break;
            n = c + 1;
            while (n < NR && !(vbl[n] && !vbl[n-1])) n++;
            if (n >= NR) break;
            pub_cyc[nexp]  = n;
            pub_trig[nexp] = real_hit;
            nexp++;
            a = n + 1;
        end
    endtask

    task automatic rand_run(input int mode);
        logic [DW-1:0] lvl;
        logic slp;
        int per, fi, v;
        slp = 1'($urandom_range(0, 1));
        case (mode)
            0:       lvl = DW'($urandom_range(500, 3500));
            1:       lvl = DW'(3000);
            default: lvl = DW'($urandom_range(200, 3800));
        endcase
        per = $urandom_range(60, 120);
        for (int n = 0; n < NR; n++) begin
            vld[n] = (mode == 2) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 3) != 0);
            case (mode)
                0:       v = $urandom_range(0, 4095);
                1:       v = $urandom_range(0, 1000);
                default: v = int'(lvl) - 64 + $urandom_range(0, 128);
            endcase
            smp[n] = DW'(v);
            vbl[n] = (n % per) < 8;
        end
        predict(lvl, slp);
        do_reset();
        fill_exp(0, 0);
        fi = 0;
        trig_level = lvl;
        trig_slope = slp;
        for (int n = 0; n < NR; n++) begin
            run = 1'b1; sample = smp[n]; sample_valid = vld[n]; vblnk = vbl[n];
            tick();
            if (fi < nexp && n == pub_cyc[fi]) begin
                check($sformatf("rand%0d_frame_ready@%0d", mode, n), frame_ready, 1);
                check($sformatf("rand%0d_triggered@%0d", mode, n), triggered, pub_trig[fi]);
                for (int i = 0; i < DEPTH; i++) exp_disp[i] = frame_mem[fi][i];
                fi++;
            end else begin
                check($sformatf("rand%0d_frame_ready@%0d", mode, n), frame_ready, 0);
            end
            check($sformatf("rand%0d_busy@%0d", mode, n), busy, 1);
            check_disp($sformatf("rand%0d_display@%0d", mode, n));
        end
    endtask

    initial begin
        int val, i, got;
        logic done;

        tbl[0] = '{12'd2048, 1'b0, 12'd2047, 12'd2048, 1'b1};
        tbl[1] = '{12'd2048, 1'b0, 12'd2048, 12'd4095, 1'b0};
        tbl[2] = '{12'd2048, 1'b0, 12'd0,    12'd2047, 1'b0};
        tbl[3] = '{12'd2048, 1'b0, 12'd2000, 12'd2100, 1'b1};
        tbl[4] = '{12'd2048, 1'b1, 12'd3000, 12'd2048, 1'b1};
        tbl[5] = '{12'd2048, 1'b1, 12'd2048, 12'd0,    1'b0};
        tbl[6] = '{12'd2048, 1'b1, 12'd2049, 12'd2047, 1'b1};
        tbl[7] = '{12'd2048, 1'b1, 12'd3000, 12'd2049, 1'b0};
        tbl[8] = '{12'd2048, 1'b1, 12'd2047, 12'd2048, 1'b0};
        tbl[9] = '{12'd0,    1'b0, 12'd0,    12'd5,    1'b0};

        do_reset();
        fill_exp(0, 0);
        check("reset_busy", busy, 0);
        check("reset_frame_ready", frame_ready, 0);
        check("reset_triggered", triggered, 0);
        check_disp("reset_display");

        for (int v = 0; v < 10; v++) begin
            do_reset();
            trig_level = tbl[v].level; trig_slope = tbl[v].slope; run = 1'b1;
            tick();
            sample_valid = 1'b1; sample = tbl[v].prev;
            tick();
            sample = tbl[v].cur;
            got = 0;
            for (int k = 0; k < 2000 && got == 0; k++) begin
                vblnk = ((k % 50) >= 45);
                tick();
                if (frame_ready) got = 1;
            end
            check($sformatf("tbl%0d_publish", v), got, 1);
            check($sformatf("tbl%0d_triggered", v), triggered, tbl[v].exp_trig);
            check($sformatf("tbl%0d_disp0", v), data_display[0], tbl[v].cur);
        end

        // run dropped in ARM returns to IDLE
        do_reset();
        run = 1'b1;
        tick();
        check("arm_busy", busy, 1);
        run = 1'b0;
        tick();
        check("arm_abort_busy", busy, 0);

        // ramp of 16 per cycle, run dropped mid-capture: frame still publishes, then IDLE
        do_reset();
        trig_level = 12'd2048; trig_slope = 1'b0; run = 1'b1; sample_valid = 1'b1; vblnk = 1'b0;
        val = 1024;
        for (int k = 0; k < 400; k++) begin
            sample = DW'(val);
            val = (val + 16) % 4096;
            if (k == 100) run = 1'b0;
            tick();
        end
        check("ramp_display_held", data_display[0], 0);
        vblnk = 1'b1;
        tick();
        check("ramp_frame_ready", frame_ready, 1);
        check("ramp_d0", data_display[0], 2048);
        check("ramp_d1", data_display[1], 2064);
        check("ramp_d128", data_display[128], 0);
        check("ramp_d255", data_display[255], 2032);
        check("ramp_triggered", triggered, 1);
        check("ramp_idle_after", busy, 0);
        fill_exp(2048, 16);
        check_disp("ramp_display");
        tick();
        check("ramp_pulse_end", frame_ready, 0);

        // auto-trigger after exactly AUTO cycles in ARM; vblnk rises on first WAIT_FRAME cycle
        do_reset();
        trig_level = 12'd2048; trig_slope = 1'b0; run = 1'b1;
        sample_valid = 1'b1; sample = 12'd1000; vblnk = 1'b0;
        tick();
        repeat (355) tick();
        check("auto_no_early_publish", frame_ready, 0);
        vblnk = 1'b1;
        tick();
        check("auto_frame_ready", frame_ready, 1);
        check("auto_triggered", triggered, 0);
        fill_exp(1000, 0);
        check_disp("auto_display");

        // vblnk already high when the frame completes: wait for fall then rise
        do_reset();
        trig_level = 12'd2048; run = 1'b1; sample_valid = 1'b1; sample = 12'd1000; vblnk = 1'b0;
        tick();
        repeat (354) tick();
        vblnk = 1'b1;
        fill_exp(0, 0);
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("vbhigh_no_publish%0d", k), frame_ready, 0);
            check_disp($sformatf("vbhigh_display_held%0d", k));
        end
        vblnk = 1'b0;
        tick();
        check("vblow_no_publish", frame_ready, 0);
        vblnk = 1'b1;
        tick();
        check("vbrise_publish", frame_ready, 1);
        fill_exp(1000, 0);
        check_disp("vbrise_display");

        // sample_valid alternating: 256 samples over 511 cycles from the trigger write
        do_reset();
        trig_level = 12'd2048; trig_slope = 1'b0; run = 1'b1; sample_valid = 1'b0; vblnk = 1'b0;
        tick();
        i = 0;
        done = 1'b0;
        while (!done && i < 200) begin
            sample_valid = (i % 2 == 0);
            sample = sample_valid ? DW'(2030 + i / 2) : 12'hFFF;
            tick();
            if (sample_valid && sample == 12'd2048) done = 1'b1;
            i++;
        end
        for (int j = 1; j <= 510; j++) begin
            sample_valid = (j % 2 == 0);
            sample = sample_valid ? DW'(2048 + j / 2) : 12'hFFF;
            tick();
        end
        sample_valid = 1'b0;
        vblnk = 1'b1;
        tick();
        check("alt_frame_ready", frame_ready, 1);
        check("alt_triggered", triggered, 1);
        fill_exp(2048, 1);
        check_disp("alt_display");

        // reset after 100 captured samples, then a fresh capture from index 0
        vblnk = 1'b0; sample_valid = 1'b1;
        for (int k = 0; k < 118; k++) begin
            sample = DW'(2030 + k);
            tick();
        end
        rst = 1'b0;
        tick();
        check("midrst_busy", busy, 0);
        check("midrst_frame_ready", frame_ready, 0);
        check("midrst_triggered", triggered, 0);
        fill_exp(0, 0);
        check_disp("midrst_display");
        rst = 1'b1; run = 1'b1;
        tick();
        for (int k = 0; k < 274; k++) begin
            sample = DW'(2030 + k);
            tick();
        end
        vblnk = 1'b1;
        tick();
        check("postrst_frame_ready", frame_ready, 1);
        fill_exp(2048, 1);
        check_disp("postrst_display");

        rand_run(0);
        rand_run(1);
        rand_run(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
